// File: rtl/param_datapath_core_if.sv
// param_datapath_core_if: instruction and data memory req/ack bundle between core and memories
interface param_datapath_core_if #(
  parameter int DATA_W = 16,
  parameter int PC_W = 8,
  parameter int DADDR_W = 8
);
  logic imem_req;
  logic [PC_W-1:0] imem_addr;
  logic imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic dmem_req;
  logic dmem_we;
  logic [DADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
  modport slave (
    input imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/param_datapath_core.sv
// param_datapath_core: multi-cycle register-file datapath with fetch/decode/exec/mem/writeback sequencer
module param_datapath_core #(
  parameter int DATA_W = 16,
  parameter int REG_CNT = 8,
  parameter int PC_W = 8,
  parameter int DADDR_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  param_datapath_core_if.master bus,
  output logic [3:0] flags,
  output logic busy,
  output logic halted,
  output logic illegal
);
  localparam int REG_AW = $clog2(REG_CNT);
  localparam int IMM_W = DATA_W - 5 - 2 * REG_AW;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;
  localparam logic [4:0] OP_ADD = 5'd1, OP_SUB = 5'd2, OP_AND = 5'd3, OP_OR = 5'd4, OP_XOR = 5'd5,
                         OP_SHL = 5'd6, OP_SHR = 5'd7, OP_LD = 5'd9, OP_ST = 5'd10,
                         OP_BZ = 5'd11, OP_JMP = 5'd12, OP_HALT = 5'd13;
  logic [2:0] state;
  logic [PC_W-1:0] pc;
  logic [DATA_W-1:0] ir, op_a, op_b, wb_val, imm, res;
  logic [DATA_W-1:0] regs [REG_CNT];
  logic wb_en, d_we, c_out, v_out, sh_ok;
  logic [DADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [4:0] op, sh;
  logic [REG_AW-1:0] rd, rs;
  logic [DATA_W:0] add_full, sub_full, shl_full, shr_full;
  assign op = ir[DATA_W-1 -: 5];
  assign rd = ir[DATA_W-6 -: REG_AW];
  assign rs = ir[DATA_W-6-REG_AW -: REG_AW];
  assign imm = {{(DATA_W - IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  assign sh = imm[4:0];
  assign sh_ok = int'(sh) < DATA_W;
  assign add_full = {1'b0, op_a} + {1'b0, op_b};
  assign sub_full = {1'b0, op_a} - {1'b0, op_b};
  assign shl_full = {1'b0, op_a} << sh;
  assign shr_full = {op_a, 1'b0} >> sh;
  // ALU result plus carry/overflow; the spare bit of each shift holds the last bit shifted out
  always_comb begin
    res = op == OP_ADD ? add_full[DATA_W-1:0] :
          op == OP_SUB ? sub_full[DATA_W-1:0] :
          op == OP_AND ? op_a & op_b :
          op == OP_OR  ? op_a | op_b :
          op == OP_XOR ? op_a ^ op_b :
          op == OP_SHL ? shl_full[DATA_W-1:0] :
          op == OP_SHR ? shr_full[DATA_W:1] : imm;
    c_out = op == OP_ADD ? add_full[DATA_W] :
            op == OP_SUB ? sub_full[DATA_W] :
            op == OP_SHL ? sh_ok & shl_full[DATA_W] :
            op == OP_SHR ? sh_ok & shr_full[0] : 1'b0;
    v_out = op == OP_ADD ? (op_a[DATA_W-1] == op_b[DATA_W-1]) && (res[DATA_W-1] != op_a[DATA_W-1]) :
            op == OP_SUB ? (op_a[DATA_W-1] != op_b[DATA_W-1]) && (res[DATA_W-1] != op_a[DATA_W-1]) : 1'b0;
  end
  // Sequencer with PC/IR, flags, operand latches and memory request registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      pc <= '0;
      ir <= '0;
      op_a <= '0;
      op_b <= '0;
      wb_val <= '0;
      wb_en <= 1'b0;
      flags <= '0;
      illegal <= 1'b0;
      d_we <= 1'b0;
      d_addr <= '0;
      d_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_FETCH;
        S_FETCH: if (bus.imem_ack) begin
          ir <= bus.imem_rdata;
          pc <= pc + PC_W'(1);
          state <= S_DECODE;
        end
        S_DECODE: begin
          op_a <= regs[rd];
          op_b <= regs[rs];
          state <= S_EXEC;
        end
        S_EXEC: begin
          wb_val <= res;
          wb_en <= op >= OP_ADD && op <= OP_LD;
          if (op >= OP_ADD && op <= OP_SHR) flags <= {res == '0, res[DATA_W-1], c_out, v_out};
          if ((op == OP_BZ && flags[3]) || op == OP_JMP) pc <= pc + imm[PC_W-1:0];
          if (op == OP_LD || op == OP_ST) begin
            d_we <= op == OP_ST;
            d_addr <= DADDR_W'(op_b + imm);
            d_wdata <= op_a;
          end
          illegal <= op > OP_HALT;
          state <= op == OP_LD || op == OP_ST ? S_MEM : op >= OP_HALT ? S_HALT : S_WB;
        end
        S_MEM: if (bus.dmem_ack) begin
          if (!d_we) wb_val <= bus.dmem_rdata;
          state <= S_WB;
        end
        S_WB: state <= S_FETCH;
        default: ;
      endcase
    end
  end
  // Register file, written only in writeback
  always_ff @(posedge clk) begin
    if (!reset) for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    else if (state == S_WB && wb_en) regs[rd] <= wb_val;
  end
  assign bus.imem_req = state == S_FETCH;
  assign bus.imem_addr = pc;
  assign bus.dmem_req = state == S_MEM;
  assign bus.dmem_we = d_we;
  assign bus.dmem_addr = d_addr;
  assign bus.dmem_wdata = d_wdata;
  assign busy = state != S_IDLE && state != S_HALT;
  assign halted = state == S_HALT;
endmodule

// File: tb/tb_param_datapath_core.sv
// tb_param_datapath_core: directed and random program checks of param_datapath_core against an ISA model
module tb_param_datapath_core;
  logic clk, reset, start;
  logic [3:0] flags;
  logic busy, halted, illegal;
  param_datapath_core_if bus ();
  param_datapath_core dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .flags(flags), .busy(busy), .halted(halted), .illegal(illegal)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int errors, checks;
  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  logic [15:0] dmem_init [256];
  int iwait_max, dwait_max, dwait_min, istall_after, iacks, dreq_len;
  bit dstable_err;
  logic last_we;
  int fetch_log [$];
  logic [27:0] st_log [$];
  logic [27:0] exp_log [$];
  // Memory responder: random or fixed wait states, acks driven on the falling edge
  initial begin
    int icnt, dcnt, iw, dw;
    logic [7:0] a0;
    logic [15:0] w0;
    logic we0;
    icnt = 0; dcnt = 0; iw = 0; dw = 0; a0 = 0; w0 = 0; we0 = 0;
    bus.imem_ack = 0; bus.dmem_ack = 0; bus.imem_rdata = 0; bus.dmem_rdata = 0;
    forever begin
      @(negedge clk);
      bus.imem_ack = 0;
      bus.dmem_ack = 0;
      if (bus.imem_req && (istall_after < 0 || iacks < istall_after)) begin
        if (icnt == 0) iw = $urandom_range(iwait_max, 0);
        if (icnt >= iw) begin
          bus.imem_ack = 1;
          bus.imem_rdata = imem[bus.imem_addr];
          fetch_log.push_back(int'(bus.imem_addr));
          iacks++;
          icnt = 0;
        end else icnt++;
      end else icnt = 0;
      if (bus.dmem_req) begin
        if (dcnt == 0) begin
          dw = $urandom_range(dwait_max, dwait_min);
          a0 = bus.dmem_addr; w0 = bus.dmem_wdata; we0 = bus.dmem_we;
        end else if (bus.dmem_addr !== a0 || bus.dmem_wdata !== w0 || bus.dmem_we !== we0) dstable_err = 1;
        dcnt++;
        if (dcnt > dw) begin
          bus.dmem_ack = 1;
          bus.dmem_rdata = dmem[bus.dmem_addr];
          last_we = bus.dmem_we;
          if (bus.dmem_we) begin
            dmem[bus.dmem_addr] = bus.dmem_wdata;
            st_log.push_back({bus.dmem_addr, bus.dmem_wdata, flags});
          end
          dreq_len = dcnt;
          dcnt = 0;
        end
      end else dcnt = 0;
    end
  end
  function automatic logic [15:0] ins(input int op, input int rd, input int rs, input int imm);
    logic [31:0] o, d, s, i;
    o = op; d = rd; s = rs; i = imm;
    return {o[4:0], d[2:0], s[2:0], i[4:0]};
  endfunction
  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = ins(13, 0, 0, 0);
  endtask
  task automatic prep();
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    fetch_log.delete();
    st_log.delete();
    dstable_err = 0;
    dreq_len = 0;
    iacks = 0;
    last_we = 0;
    for (int i = 0; i < 256; i++) dmem[i] = dmem_init[i];
  endtask
  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  // cyc = rising edges after the start edge until halted is seen
  task automatic run_to_halt(input int limit, output int cyc);
    pulse_start();
    cyc = 0;
    while (halted !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  // Instruction-level reference: integer arithmetic straight from the ISA rules
  task automatic ref_run(output logic [3:0] ef, output bit eill, output int ecyc);
    int r [8];
    int m [256];
    int pc, op, rd, rs, imm, amt, a, b, res, ad;
    bit z, n, c, v;
    logic [15:0] w;
    z = 0; n = 0; c = 0; v = 0; pc = 0; eill = 0; ecyc = 0; res = 0;
    exp_log.delete();
    for (int i = 0; i < 8; i++) r[i] = 0;
    for (int i = 0; i < 256; i++) m[i] = int'(dmem_init[i]);
    for (int k = 0; k < 2000; k++) begin
      w = imem[pc];
      pc = (pc + 1) % 256;
      op = int'(w[15:11]); rd = int'(w[10:8]); rs = int'(w[7:5]); amt = int'(w[4:0]);
      imm = amt >= 16 ? amt - 32 : amt;
      a = r[rd]; b = r[rs]; ad = (b + imm) & 255;
      if (op >= 13) begin
        eill = op > 13;
        ecyc += 3;
        break;
      end
      ecyc += (op == 9 || op == 10) ? 5 : 4;
      if (op >= 1 && op <= 7) begin
        c = 0; v = 0;
        if (op == 1) begin
          res = (a + b) % 65536;
          c = a + b >= 65536;
          v = ((a >= 32768) == (b >= 32768)) && ((res >= 32768) != (a >= 32768));
        end else if (op == 2) begin
          res = (a - b + 65536) % 65536;
          c = a < b;
          v = ((a >= 32768) != (b >= 32768)) && ((res >= 32768) != (a >= 32768));
        end else if (op == 3) res = a & b;
        else if (op == 4) res = a | b;
        else if (op == 5) res = a ^ b;
        else if (amt == 0) res = a;
        else if (amt >= 16) res = 0;
        else if (op == 6) begin
          res = int'((longint'(a) * (longint'(1) << amt)) % 65536);
          c = ((a >> (16 - amt)) & 1) == 1;
        end else begin
          res = a >> amt;
          c = ((a >> (amt - 1)) & 1) == 1;
        end
        z = res == 0;
        n = res >= 32768;
        r[rd] = res;
      end else if (op == 8) r[rd] = imm & 65535;
      else if (op == 9) r[rd] = m[ad];
      else if (op == 10) begin
        m[ad] = a;
        exp_log.push_back({8'(ad), 16'(a), z, n, c, v});
      end else if ((op == 11 && z) || op == 12) pc = (pc + imm) & 255;
    end
    ef = {z, n, c, v};
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.imem_req, bus.dmem_req, bus.dmem_we, busy, halted, illegal, flags, bus.imem_addr, bus.dmem_addr, bus.dmem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {bus.imem_req, bus.dmem_req, bus.dmem_we, busy, halted, illegal, flags, bus.imem_addr, bus.dmem_addr, bus.dmem_wdata});
    end
    clear_imem();
    imem[0] = ins(8, 1, 0, 1);
    imem[1] = ins(6, 1, 0, 15);
    prep();
    istall_after = 2;
    pulse_start();
    repeat (20) @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'd2) begin
      errors++;
      $display("FAIL stall_fetch got=req%b addr%0d exp=req1 addr2", bus.imem_req, bus.imem_addr);
    end
    checks++;
    if (flags !== 4'b0100) begin errors++; $display("FAIL pre_reset_flags got=%b exp=0100", flags); end
    reset = 0;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL abort_req got=%b exp=0", bus.imem_req); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++;
    if (bus.imem_addr !== 8'd0) begin errors++; $display("FAIL abort_pc got=%0d exp=0", bus.imem_addr); end
    checks++;
    if (flags !== 4'b0000) begin errors++; $display("FAIL abort_flags got=%b exp=0000", flags); end
    reset = 1;
    istall_after = -1;
  endtask
  task automatic test_add();
    int cyc;
    clear_imem();
    imem[0] = ins(8, 1, 0, 5);
    imem[1] = ins(8, 2, 0, -3);
    imem[2] = ins(1, 1, 2, 0);
    prep();
    run_to_halt(100, cyc);
    checks++;
    if (cyc !== 15) begin errors++; $display("FAIL add_halt_edges got=%0d exp=15", cyc); end
    checks++;
    if (flags !== 4'b0010) begin errors++; $display("FAIL add_flags got=%b exp=0010", flags); end
    checks++;
    if (busy !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL add_status got=busy%b ill%b exp=busy0 ill0", busy, illegal); end
    imem[3] = ins(10, 1, 0, 0);
    prep();
    run_to_halt(100, cyc);
    checks++;
    if (st_log.size() !== 1 || st_log[0] !== {8'd0, 16'd2, 4'b0010}) begin
      errors++;
      $display("FAIL add_r1 got=%0d stores first=%h exp=1 stores %h", st_log.size(), st_log.size() > 0 ? st_log[0] : 28'h0, {8'd0, 16'd2, 4'b0010});
    end
  endtask
  task automatic test_branch();
    int cyc;
    int exp_f [5] = '{0, 1, 2, 4, 5};
    clear_imem();
    imem[0] = ins(8, 1, 0, 1);
    imem[1] = ins(2, 1, 1, 0);
    imem[2] = ins(11, 0, 0, 1);
    imem[3] = ins(8, 3, 0, 7);
    imem[4] = ins(10, 3, 0, 0);
    prep();
    run_to_halt(200, cyc);
    checks++;
    if (fetch_log.size() !== 5) begin errors++; $display("FAIL bz_fetch_count got=%0d exp=5", fetch_log.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++;
      if (fetch_log[i] !== exp_f[i]) begin errors++; $display("FAIL bz_fetch%0d got=%0d exp=%0d", i, fetch_log[i], exp_f[i]); end
    end
    checks++;
    if (st_log.size() !== 1 || st_log[0] !== {8'd0, 16'd0, 4'b1000}) begin
      errors++;
      $display("FAIL bz_r3 got=%0d stores first=%h exp=1 stores %h", st_log.size(), st_log.size() > 0 ? st_log[0] : 28'h0, {8'd0, 16'd0, 4'b1000});
    end
  endtask
  task automatic test_store_wait();
    int cyc;
    clear_imem();
    imem[0] = ins(8, 1, 0, -7);
    imem[1] = ins(8, 2, 0, 5);
    imem[2] = ins(10, 1, 2, 2);
    dwait_min = 3;
    dwait_max = 3;
    prep();
    run_to_halt(200, cyc);
    checks++;
    if (dreq_len !== 4) begin errors++; $display("FAIL st_req_cycles got=%0d exp=4", dreq_len); end
    checks++;
    if (dstable_err !== 1'b0) begin errors++; $display("FAIL st_stable got=%b exp=0", dstable_err); end
    checks++;
    if (last_we !== 1'b1 || st_log.size() !== 1 || st_log[0] !== {8'd7, 16'hfff9, 4'b0000}) begin
      errors++;
      $display("FAIL st_data got=we%b n%0d %h exp=we1 n1 %h", last_we, st_log.size(), st_log.size() > 0 ? st_log[0] : 28'h0, {8'd7, 16'hfff9, 4'b0000});
    end
    dwait_min = 0;
    dwait_max = 0;
  endtask
  task automatic test_shift();
    int cyc;
    logic [27:0] exp_s [3];
    exp_s[0] = {8'd0, 16'h8000, 4'b0100};
    exp_s[1] = {8'd1, 16'h0000, 4'b1010};
    exp_s[2] = {8'd2, 16'h0000, 4'b1000};
    clear_imem();
    imem[0] = ins(8, 1, 0, 1);
    imem[1] = ins(6, 1, 0, 15);
    imem[2] = ins(10, 1, 0, 0);
    imem[3] = ins(6, 1, 0, 1);
    imem[4] = ins(10, 1, 0, 1);
    imem[5] = ins(8, 3, 0, 1);
    imem[6] = ins(6, 3, 0, 16);
    imem[7] = ins(10, 3, 0, 2);
    prep();
    run_to_halt(200, cyc);
    checks++;
    if (st_log.size() !== 3) begin errors++; $display("FAIL shl_store_count got=%0d exp=3", st_log.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (st_log[i] !== exp_s[i]) begin errors++; $display("FAIL shl_step%0d got=%h exp=%h", i, st_log[i], exp_s[i]); end
    end
  endtask
  task automatic test_illegal_wrap();
    int cyc;
    bit bad;
    int exp_f [4] = '{0, 1, 255, 2};
    clear_imem();
    imem[0] = ins(8, 1, 0, 3);
    imem[1] = ins(31, 1, 0, 0);
    prep();
    run_to_halt(100, cyc);
    checks++;
    if (illegal !== 1'b1 || halted !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_status got=ill%b halt%b busy%b exp=ill1 halt1 busy0", illegal, halted, busy);
    end
    pulse_start();
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.imem_req !== 1'b0 || halted !== 1'b1 || bus.imem_addr !== 8'd2) bad = 1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL halt_ignores_start got=%b exp=0", bad); end
    clear_imem();
    imem[0] = ins(2, 0, 0, 0);
    imem[1] = ins(11, 0, 0, -3);
    imem[255] = ins(12, 0, 0, 2);
    prep();
    run_to_halt(100, cyc);
    checks++;
    if (fetch_log.size() !== 4) begin errors++; $display("FAIL wrap_fetch_count got=%0d exp=4", fetch_log.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (fetch_log[i] !== exp_f[i]) begin errors++; $display("FAIL wrap_fetch%0d got=%0d exp=%0d", i, fetch_log[i], exp_f[i]); end
    end
    checks++;
    if (illegal !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL wrap_status got=ill%b halt%b exp=ill0 halt1", illegal, halted); end
  endtask
  task automatic test_random();
    int cyc, ecyc, op;
    logic [3:0] ef;
    bit eill, zw;
    for (int t = 0; t < 24; t++) begin
      zw = t % 2 == 0;
      iwait_max = zw ? 0 : 3;
      dwait_max = zw ? 0 : 3;
      for (int i = 0; i < 256; i++) dmem_init[i] = 16'($urandom);
      clear_imem();
      for (int i = 0; i < 16; i++) begin
        op = $urandom_range(12, 0);
        imem[i] = ins(op, $urandom_range(7, 0), $urandom_range(7, 0), (op == 11 || op == 12) ? $urandom_range(7, 0) : $urandom_range(31, 0));
      end
      for (int i = 0; i < 8; i++) imem[16 + i] = ins(10, i, 0, i);
      imem[24] = ins($urandom_range(3, 0) == 0 ? $urandom_range(31, 14) : 13, 1, 2, 0);
      ref_run(ef, eill, ecyc);
      prep();
      run_to_halt(3000, cyc);
      checks++;
      if (halted !== 1'b1) begin errors++; $display("FAIL rnd%0d_halt got=%b exp=1", t, halted); end
      if (zw) begin
        checks++;
        if (cyc !== ecyc) begin errors++; $display("FAIL rnd%0d_cycles got=%0d exp=%0d", t, cyc, ecyc); end
      end
      checks++;
      if (flags !== ef) begin errors++; $display("FAIL rnd%0d_flags got=%b exp=%b", t, flags, ef); end
      checks++;
      if (illegal !== eill) begin errors++; $display("FAIL rnd%0d_illegal got=%b exp=%b", t, illegal, eill); end
      checks++;
      if (st_log.size() !== exp_log.size()) begin
        errors++;
        $display("FAIL rnd%0d_store_count got=%0d exp=%0d", t, st_log.size(), exp_log.size());
      end else for (int i = 0; i < st_log.size(); i++) begin
        checks++;
        if (st_log[i] !== exp_log[i]) begin errors++; $display("FAIL rnd%0d_store%0d got=%h exp=%h", t, i, st_log[i], exp_log[i]); end
      end
    end
    iwait_max = 0;
    dwait_max = 0;
  endtask
  initial begin
    errors = 0; checks = 0;
    reset = 0; start = 0;
    iwait_max = 0; dwait_max = 0; dwait_min = 0; istall_after = -1; iacks = 0;
    dreq_len = 0; dstable_err = 0; last_we = 0;
    for (int i = 0; i < 256; i++) dmem_init[i] = 16'($urandom);
    test_reset();
    test_add();
    test_branch();
    test_store_wait();
    test_shift();
    test_illegal_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
